// File: rtl/sched_pkg.sv
// Shared scheduling types and FP32 field constants for the score selection path.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          FP32_SIGN_BIT  = 31;
  localparam logic [7:0]  FP32_EXP_ONES  = 8'hFF;
  localparam logic [22:0] FP32_MANT_MASK = 23'h7F_FFFF;
  localparam logic [31:0] FP32_POS_ZERO  = 32'h0000_0000;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[30:23] == FP32_EXP_ONES) && ((v[22:0] & FP32_MANT_MASK) != '0);
  endfunction

endpackage

// File: rtl/fp32_less_than.sv
// Combinational FP32 a < b in sign-magnitude order; +0 and -0 compare equal.
// Latency: 0 cycles. Backpressure: none (pure function of a and b).
module fp32_less_than
  import sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt,
  output logic        a_nan
);

  logic [30:0] a_mag;
  logic [30:0] b_mag;
  logic        a_neg;
  logic        b_neg;

  always_comb begin
    a_mag = a[30:0];
    b_mag = b[30:0];
    a_neg = a[FP32_SIGN_BIT];
    b_neg = b[FP32_SIGN_BIT];
    a_nan = fp32_is_nan(a);
    lt    = 1'b0;
    // Two zeros of any sign are equal; otherwise the sign picks the magnitude order.
    if (!((a_mag == '0) && (b_mag == '0))) begin
      unique case ({a_neg, b_neg})
        2'b00:   lt = (a_mag < b_mag);
        2'b11:   lt = (a_mag > b_mag);
        2'b10:   lt = 1'b1;
        default: lt = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/score_select_arbiter.sv
// Scans active task slots, requests one score per slot, returns the minimum-score slot.
// Latency: 1 + sum(1 + L_i) over active slots + 1 per inactive slot; result held until sel_rdy.
// Backpressure: sel_vld holds in DONE until sel_rdy; optional SCORE_TIMEOUT_EN bounds each WAIT.
module score_select_arbiter
  import sched_pkg::*;
#(
  parameter int NUM_TASKS      = 4,
  parameter int TASK_ID_WIDTH  = 2,
  parameter int SCORE_BITWIDTH = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_TASKS-1:0]      task_active,
  output logic                      calc_mode,
  output logic                      calc_req_vld,
  output logic [TASK_ID_WIDTH-1:0]  calc_req_id,
  input  logic [SCORE_BITWIDTH-1:0] score_dat,
  input  logic                      score_vld,
  output logic                      sel_vld,
  input  logic                      sel_rdy,
  output logic [TASK_ID_WIDTH-1:0]  sel_id,
  output logic [SCORE_BITWIDTH-1:0] sel_score,
  output logic                      sel_none,
  output logic                      busy,
  output logic                      timeout_err
);

  if (NUM_TASKS < 2 || TASK_ID_WIDTH != $clog2(NUM_TASKS) ||
      SCORE_BITWIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("score_select_arbiter: unsupported parameter set");
  end

  state_e                      state;
  logic [TASK_ID_WIDTH-1:0]    ptr;
  logic [NUM_TASKS-1:0]        mask;
  logic                        best_vld;
  logic [SCORE_BITWIDTH-1:0]   best_score;
  logic [TASK_ID_WIDTH-1:0]    best_id;

  logic                        cand_lt;
  logic                        cand_nan;
  logic                        to_fire;
  logic                        last;
  logic [TASK_ID_WIDTH-1:0]    ptr_inc;
  logic                        wait_done;
  logic                        upd;
  logic                        best_vld_nxt;
  logic [SCORE_BITWIDTH-1:0]   best_score_nxt;
  logic [TASK_ID_WIDTH-1:0]    best_id_nxt;
  logic [TASK_ID_WIDTH-1:0]    sel_id_nxt;
  logic [SCORE_BITWIDTH-1:0]   sel_score_nxt;

  assign calc_mode = 1'b1;

  fp32_less_than u_cmp (
    .a     (score_dat),
    .b     (best_score),
    .lt    (cand_lt),
    .a_nan (cand_nan)
  );

  always_comb begin
    last      = (ptr == TASK_ID_WIDTH'(NUM_TASKS - 1));
    ptr_inc   = ptr + TASK_ID_WIDTH'(1);
    wait_done = (state == WAIT) && (score_vld || to_fire);
    // Strict less-than keeps the earlier slot on ties; NaN never wins.
    upd       = (state == WAIT) && score_vld && !cand_nan && (!best_vld || cand_lt);
    best_vld_nxt   = best_vld | upd;
    best_score_nxt = upd ? score_dat : best_score;
    best_id_nxt    = upd ? ptr : best_id;
    sel_id_nxt     = best_vld_nxt ? best_id_nxt : '0;
    sel_score_nxt  = best_vld_nxt ? best_score_nxt : SCORE_BITWIDTH'(FP32_POS_ZERO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      mask         <= '0;
      best_vld     <= 1'b0;
      best_score   <= SCORE_BITWIDTH'(FP32_POS_ZERO);
      best_id      <= '0;
      calc_req_vld <= 1'b0;
      calc_req_id  <= '0;
      sel_vld      <= 1'b0;
      sel_id       <= '0;
      sel_score    <= '0;
      sel_none     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      calc_req_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= ISSUE;
            ptr          <= '0;
            mask         <= task_active;
            best_vld     <= 1'b0;
            best_score   <= SCORE_BITWIDTH'(FP32_POS_ZERO);
            best_id      <= '0;
            busy         <= 1'b1;
            calc_req_id  <= '0;
            calc_req_vld <= task_active[0];
          end
        end
        ISSUE, WAIT: begin
          best_vld   <= best_vld_nxt;
          best_score <= best_score_nxt;
          best_id    <= best_id_nxt;
          if (state == ISSUE && mask[ptr]) begin
            state <= WAIT;
          end else if (state == ISSUE || wait_done) begin
            if (last) begin
              state     <= DONE;
              sel_vld   <= 1'b1;
              sel_none  <= ~best_vld_nxt;
              sel_id    <= sel_id_nxt;
              sel_score <= sel_score_nxt;
            end else begin
              // Request pulse is registered here so it lines up with the ISSUE cycle of the next slot.
              state        <= ISSUE;
              ptr          <= ptr_inc;
              calc_req_id  <= ptr_inc;
              calc_req_vld <= mask[ptr_inc];
            end
          end
        end
        DONE: begin
          if (sel_rdy) begin
            state     <= IDLE;
            sel_vld   <= 1'b0;
            sel_none  <= 1'b0;
            sel_id    <= '0;
            sel_score <= '0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_fire = (state == WAIT) && !score_vld && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT && !score_vld && !to_fire) to_cnt <= to_cnt + TO_W'(1);
      else                                         to_cnt <= '0;
      if (state == IDLE && start) timeout_err <= 1'b0;
      else if (to_fire)           timeout_err <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
